// File: rtl/loss_grad_unit.sv
// Streams tensors A/B and writes the element-wise MSE gradient to D or the scalar sum of squared errors.
// Zero-wait: 7 header cycles, 3/element (gradient) or 2/element + 1 (loss); each handshake state stalls until its ack.
module loss_grad_unit #(
   parameter int WIDTH     = 32,
   parameter int FRAC_BITS = 16,
   parameter int ADDR_W    = 16
) (
   input  logic              clk,
   input  logic              rst_l,
   input  logic              go,
   input  logic              mode,
   input  logic [4:0]        grad_shift,
   input  logic [ADDR_W-1:0] a_begin,
   input  logic [ADDR_W-1:0] a_end,
   input  logic [ADDR_W-1:0] b_begin,
   input  logic [ADDR_W-1:0] b_end,
   input  logic [ADDR_W-1:0] d_begin,
   output logic              done,
   output logic              err,
   output logic              a_rd_en,
   output logic [ADDR_W-1:0] a_addr,
   input  logic              a_ack,
   input  logic [WIDTH-1:0]  a_rdata,
   output logic              b_rd_en,
   output logic [ADDR_W-1:0] b_addr,
   input  logic              b_ack,
   input  logic [WIDTH-1:0]  b_rdata,
   output logic              d_wr_en,
   output logic [ADDR_W-1:0] d_addr,
   output logic [WIDTH-1:0]  d_wdata,
   output logic              d_flush,
   input  logic              d_ack
);

   localparam int ACC_W = 2*WIDTH + 2;
   localparam logic [ADDR_W-1:0] ONE_A = 1;
   localparam logic [ADDR_W-1:0] TWO_A = 2;
   localparam logic [WIDTH-1:0]  ONE_W = 1;
   localparam logic signed [WIDTH+1:0] G_MAX = {3'b000, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH+1:0] G_MIN = {3'b111, {(WIDTH-1){1'b0}}};
   localparam logic [ACC_W-1:0] L_MAX = {{(WIDTH+3){1'b0}}, {(WIDTH-1){1'b1}}};

   typedef struct packed {
      logic [WIDTH-1:0] rows;
      logic [WIDTH-1:0] cols;
   } hdr_t;

   typedef enum logic [3:0] {
      S_IDLE, S_HDR_RD, S_CHECK, S_HDR_WR0, S_HDR_WR1,
      S_RD, S_EXEC, S_WR, S_LOSS_WR, S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic               mode_q, mode_d;
   logic [4:0]         shift_q, shift_d;
   logic [ADDR_W-1:0]  a_base_q, a_base_d, b_base_q, b_base_d, d_base_q, d_base_d;
   logic [ADDR_W-1:0]  n_a_q, n_a_d, n_b_q, n_b_d, idx_q, idx_d;
   hdr_t               a_hdr_q, a_hdr_d, b_hdr_q, b_hdr_d;
   logic [1:0]         hdr_idx_q, hdr_idx_d;
   logic               a_got_q, a_got_d, b_got_q, b_got_d, err_q, err_d;
   logic [WIDTH-1:0]   a_dat_q, a_dat_d, b_dat_q, b_dat_d, g_q, g_d;
   logic [ACC_W-1:0]   acc_q, acc_d;

   logic                     last;
   logic                     a_fire, b_fire;
   logic signed [WIDTH:0]    diff;
   logic signed [WIDTH+1:0]  dbl, g_sh;
   logic [WIDTH-1:0]         g_sat, loss_out;
   logic signed [ACC_W-1:0]  sq_s;
   logic [ACC_W-1:0]         sq_sh, acc_nxt;
   logic [ACC_W:0]           acc_sum;

   assign last   = (idx_q == n_a_q - ONE_A);
   assign a_fire = a_rd_en & a_ack;
   assign b_fire = b_rd_en & b_ack;
   assign err    = err_q;

   // One extra bit keeps a - b exact for any pair of WIDTH-bit operands.
   assign diff    = {a_dat_q[WIDTH-1], a_dat_q} - {b_dat_q[WIDTH-1], b_dat_q};
   assign dbl     = {diff, 1'b0};
   assign g_sh    = dbl >>> shift_q;
   assign sq_s    = diff * diff;
   assign sq_sh   = $unsigned(sq_s) >> FRAC_BITS;
   assign acc_sum = {1'b0, acc_q} + {1'b0, sq_sh};
   assign acc_nxt = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];

   always_comb begin
      if (g_sh > G_MAX)      g_sat = G_MAX[WIDTH-1:0];
      else if (g_sh < G_MIN) g_sat = G_MIN[WIDTH-1:0];
      else                   g_sat = g_sh[WIDTH-1:0];
      loss_out = (acc_q > L_MAX) ? L_MAX[WIDTH-1:0] : acc_q[WIDTH-1:0];
   end

   // Port outputs are pure decodes of registered state, so they cannot glitch.
   always_comb begin
      done    = 1'b0;
      a_rd_en = 1'b0;
      a_addr  = '0;
      b_rd_en = 1'b0;
      b_addr  = '0;
      d_wr_en = 1'b0;
      d_addr  = '0;
      d_wdata = '0;
      d_flush = 1'b0;
      case (state_q)
         S_HDR_RD: begin
            if (!hdr_idx_q[1]) begin
               a_rd_en = 1'b1;
               a_addr  = a_base_q + ADDR_W'(hdr_idx_q[0]);
            end else begin
               b_rd_en = 1'b1;
               b_addr  = b_base_q + ADDR_W'(hdr_idx_q[0]);
            end
         end
         S_HDR_WR0: begin
            d_wr_en = 1'b1;
            d_addr  = d_base_q;
            d_wdata = mode_q ? ONE_W : a_hdr_q.rows;
         end
         S_HDR_WR1: begin
            d_wr_en = 1'b1;
            d_addr  = d_base_q + ONE_A;
            d_wdata = mode_q ? ONE_W : a_hdr_q.cols;
            d_flush = !mode_q && (n_a_q == '0);
         end
         S_RD: begin
            if (!a_got_q) begin
               a_rd_en = 1'b1;
               a_addr  = a_base_q + TWO_A + idx_q;
            end
            if (!b_got_q) begin
               b_rd_en = 1'b1;
               b_addr  = b_base_q + TWO_A + idx_q;
            end
         end
         S_WR: begin
            d_wr_en = 1'b1;
            d_addr  = d_base_q + TWO_A + idx_q;
            d_wdata = g_q;
            d_flush = last;
         end
         S_LOSS_WR: begin
            d_wr_en = 1'b1;
            d_addr  = d_base_q + TWO_A;
            d_wdata = loss_out;
            d_flush = 1'b1;
         end
         S_DONE:  done = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      shift_d   = shift_q;
      a_base_d  = a_base_q;
      b_base_d  = b_base_q;
      d_base_d  = d_base_q;
      n_a_d     = n_a_q;
      n_b_d     = n_b_q;
      idx_d     = idx_q;
      a_hdr_d   = a_hdr_q;
      b_hdr_d   = b_hdr_q;
      hdr_idx_d = hdr_idx_q;
      a_got_d   = a_got_q;
      b_got_d   = b_got_q;
      err_d     = err_q;
      a_dat_d   = a_dat_q;
      b_dat_d   = b_dat_q;
      g_d       = g_q;
      acc_d     = acc_q;
      case (state_q)
         S_IDLE: if (go) begin
            mode_d    = mode;
            shift_d   = grad_shift;
            a_base_d  = a_begin;
            b_base_d  = b_begin;
            d_base_d  = d_begin;
            n_a_d     = a_end - a_begin - TWO_A;
            n_b_d     = b_end - b_begin - TWO_A;
            idx_d     = '0;
            hdr_idx_d = '0;
            a_got_d   = 1'b0;
            b_got_d   = 1'b0;
            acc_d     = '0;
            err_d     = 1'b0;
            state_d   = S_HDR_RD;
         end
         S_HDR_RD: begin
            if (a_fire) begin
               if (hdr_idx_q[0]) a_hdr_d.cols = a_rdata;
               else              a_hdr_d.rows = a_rdata;
               hdr_idx_d = hdr_idx_q + 2'd1;
            end
            if (b_fire) begin
               if (hdr_idx_q[0]) b_hdr_d.cols = b_rdata;
               else              b_hdr_d.rows = b_rdata;
               hdr_idx_d = hdr_idx_q + 2'd1;
               if (hdr_idx_q == 2'd3) state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if ((a_hdr_q != b_hdr_q) || (n_a_q != n_b_q)) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               state_d = S_HDR_WR0;
            end
         end
         S_HDR_WR0: if (d_ack) state_d = S_HDR_WR1;
         S_HDR_WR1: if (d_ack) begin
            if (n_a_q != '0)  state_d = S_RD;
            else if (mode_q)  state_d = S_LOSS_WR;
            else              state_d = S_DONE;
         end
         S_RD: begin
            if (a_fire) begin
               a_dat_d = a_rdata;
               a_got_d = 1'b1;
            end
            if (b_fire) begin
               b_dat_d = b_rdata;
               b_got_d = 1'b1;
            end
            if ((a_got_q || a_fire) && (b_got_q || b_fire)) begin
               a_got_d = 1'b0;
               b_got_d = 1'b0;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (mode_q) begin
               acc_d = acc_nxt;
               if (last) begin
                  state_d = S_LOSS_WR;
               end else begin
                  idx_d   = idx_q + ONE_A;
                  state_d = S_RD;
               end
            end else begin
               g_d     = g_sat;
               state_d = S_WR;
            end
         end
         S_WR: if (d_ack) begin
            if (last) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + ONE_A;
               state_d = S_RD;
            end
         end
         S_LOSS_WR: if (d_ack) state_d = S_DONE;
         S_DONE: if (!go) begin
            err_d   = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q   <= S_IDLE;
         mode_q    <= 1'b0;
         shift_q   <= '0;
         a_base_q  <= '0;
         b_base_q  <= '0;
         d_base_q  <= '0;
         n_a_q     <= '0;
         n_b_q     <= '0;
         idx_q     <= '0;
         a_hdr_q   <= '0;
         b_hdr_q   <= '0;
         hdr_idx_q <= '0;
         a_got_q   <= 1'b0;
         b_got_q   <= 1'b0;
         err_q     <= 1'b0;
         a_dat_q   <= '0;
         b_dat_q   <= '0;
         g_q       <= '0;
         acc_q     <= '0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         shift_q   <= shift_d;
         a_base_q  <= a_base_d;
         b_base_q  <= b_base_d;
         d_base_q  <= d_base_d;
         n_a_q     <= n_a_d;
         n_b_q     <= n_b_d;
         idx_q     <= idx_d;
         a_hdr_q   <= a_hdr_d;
         b_hdr_q   <= b_hdr_d;
         hdr_idx_q <= hdr_idx_d;
         a_got_q   <= a_got_d;
         b_got_q   <= b_got_d;
         err_q     <= err_d;
         a_dat_q   <= a_dat_d;
         b_dat_q   <= b_dat_d;
         g_q       <= g_d;
         acc_q     <= acc_d;
      end
   end

endmodule

// File: tb/tb_loss_grad_unit.sv
// Self-checking bench for loss_grad_unit: memory responders with programmable ack delay and a job-level reference model.
module tb_loss_grad_unit;

   logic        clk = 1'b0;
   logic        rst_l = 1'b0;
   logic        go = 1'b0, mode = 1'b0;
   logic [4:0]  grad_shift = '0;
   logic [15:0] a_begin = '0, a_end = '0, b_begin = '0, b_end = '0, d_begin = '0;
   logic        done, err;
   logic        a_rd_en, b_rd_en, d_wr_en, d_flush;
   logic [15:0] a_addr, b_addr, d_addr;
   logic        a_ack = 1'b0, b_ack = 1'b0, d_ack = 1'b0;
   logic [31:0] a_rdata = '0, b_rdata = '0, d_wdata;

   loss_grad_unit #(.WIDTH(32), .FRAC_BITS(16), .ADDR_W(16)) dut (
      .clk(clk), .rst_l(rst_l), .go(go), .mode(mode), .grad_shift(grad_shift),
      .a_begin(a_begin), .a_end(a_end), .b_begin(b_begin), .b_end(b_end), .d_begin(d_begin),
      .done(done), .err(err),
      .a_rd_en(a_rd_en), .a_addr(a_addr), .a_ack(a_ack), .a_rdata(a_rdata),
      .b_rd_en(b_rd_en), .b_addr(b_addr), .b_ack(b_ack), .b_rdata(b_rdata),
      .d_wr_en(d_wr_en), .d_addr(d_addr), .d_wdata(d_wdata), .d_flush(d_flush), .d_ack(d_ack)
   );

   initial forever #5 clk = ~clk;

   int checks = 0, errors = 0;
   int cyc = 0;
   logic [31:0] mem_a [256];
   logic [31:0] mem_b [256];
   int a_delay = 0, b_delay = 0, d_delay = 0;
   int a_wait = 0, b_wait = 0, d_wait = 0;
   logic [15:0] got_addr[$];
   logic [31:0] got_data[$];
   bit          got_flush[$];
   logic [15:0] exp_addr[$];
   logic [31:0] exp_data[$];
   bit          exp_flush[$];
   bit          exp_err;
   int  last_ack_cyc = 0, done_rise_cyc = 0;
   bit  done_prev = 0, wr_seen = 0;
   int  b_run = 0;
   int  b_runs[$];
   logic [15:0] b_thresh = 16'hFFFF;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Memory responders and monitors act on the falling edge, away from the DUT's sampling edge.
   initial forever begin
      @(negedge clk);
      if (a_rd_en) begin
         if (a_wait >= a_delay) begin a_ack = 1; a_rdata = mem_a[a_addr[7:0]]; a_wait = 0; end
         else begin a_ack = 0; a_wait++; end
      end else begin a_ack = 0; a_wait = 0; end
      if (b_rd_en) begin
         if (b_wait >= b_delay) begin b_ack = 1; b_rdata = mem_b[b_addr[7:0]]; b_wait = 0; end
         else begin b_ack = 0; b_wait++; end
      end else begin b_ack = 0; b_wait = 0; end
      if (d_wr_en) begin
         wr_seen = 1;
         if (d_wait >= d_delay) begin
            d_ack = 1; d_wait = 0; last_ack_cyc = cyc;
            got_addr.push_back(d_addr); got_data.push_back(d_wdata); got_flush.push_back(d_flush);
         end else begin d_ack = 0; d_wait++; end
      end else begin d_ack = 0; d_wait = 0; end
      if (done && !done_prev) done_rise_cyc = cyc;
      done_prev = done;
      if (b_rd_en && b_addr >= b_thresh) b_run++;
      else if (b_run > 0) begin b_runs.push_back(b_run); b_run = 0; end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_hdr(input bit to_b, input int base, input int rows, input int cols);
      if (to_b) begin mem_b[base] = rows; mem_b[base+1] = cols; end
      else      begin mem_a[base] = rows; mem_a[base+1] = cols; end
   endtask

   // Reference: expected D write list and error flag for one job, from the tensor contents in memory.
   task automatic model_job(input bit md, input int sh, input int abeg, input int aend,
                            input int bbeg, input int bend, input int dbeg);
      int na, nb;
      longint diff, g, mag;
      logic [95:0] acc, m;
      exp_addr.delete(); exp_data.delete(); exp_flush.delete();
      na = aend - abeg - 2;
      nb = bend - bbeg - 2;
      exp_err = (mem_a[abeg] != mem_b[bbeg]) || (mem_a[abeg+1] != mem_b[bbeg+1]) || (na != nb);
      if (exp_err) return;
      exp_addr.push_back(16'(dbeg));   exp_data.push_back(md ? 32'd1 : mem_a[abeg]);   exp_flush.push_back(0);
      exp_addr.push_back(16'(dbeg+1)); exp_data.push_back(md ? 32'd1 : mem_a[abeg+1]); exp_flush.push_back(!md && na == 0);
      acc = 0;
      for (int i = 0; i < na; i++) begin
         diff = longint'($signed(mem_a[abeg+2+i])) - longint'($signed(mem_b[bbeg+2+i]));
         if (!md) begin
            g = (2 * diff) >>> sh;
            if (g > 64'sd2147483647) g = 64'sd2147483647;
            if (g < -64'sd2147483648) g = -64'sd2147483648;
            exp_addr.push_back(16'(dbeg+2+i)); exp_data.push_back(g[31:0]); exp_flush.push_back(i == na-1);
         end else begin
            mag = (diff < 0) ? -diff : diff;
            m = 96'(mag);
            acc = acc + ((m * m) >> 16);
         end
      end
      if (md) begin
         exp_addr.push_back(16'(dbeg+2));
         exp_data.push_back((acc > 96'd2147483647) ? 32'h7FFFFFFF : acc[31:0]);
         exp_flush.push_back(1);
      end
   endtask

   task automatic run_job(input bit md, input int sh, input int abeg, input int aend, input int bbeg,
                          input int bend, input int dbeg, output int cycles, output bit to, output bit err_seen);
      got_addr.delete(); got_data.delete(); got_flush.delete();
      wr_seen = 0;
      mode = md; grad_shift = 5'(sh);
      a_begin = 16'(abeg); a_end = 16'(aend); b_begin = 16'(bbeg); b_end = 16'(bend); d_begin = 16'(dbeg);
      go = 1; cycles = 0; to = 1;
      for (int k = 0; k < 3000; k++) begin
         @(posedge clk); cycles++; #1;
         if (done) begin to = 0; break; end
      end
      err_seen = err;
      go = 0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst_l = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({done, err, a_rd_en, b_rd_en, d_wr_en, d_flush} !== 6'b0) begin
         errors++; $display("FAIL reset_ctrl got %b want 000000", {done, err, a_rd_en, b_rd_en, d_wr_en, d_flush});
      end
      checks++;
      if ({a_addr, b_addr, d_addr} !== 48'h0) begin
         errors++; $display("FAIL reset_addr got %h %h %h want 0", a_addr, b_addr, d_addr);
      end
      checks++;
      if (d_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", d_wdata); end
      rst_l = 1;
      @(posedge clk); #1;
   endtask

   task automatic load_plan_tensors;
      set_hdr(0, 0, 2, 2);
      mem_a[2] = 32'h0001_0000; mem_a[3] = 32'h0002_0000; mem_a[4] = 32'hFFFF_0000; mem_a[5] = 32'h0000_8000;
      set_hdr(1, 16, 2, 2);
      mem_b[18] = 32'h0000_8000; mem_b[19] = 32'h0002_0000; mem_b[20] = 32'h0001_0000; mem_b[21] = 32'h0;
   endtask

   task automatic test_grad_plan;
      int cy; bit to, es;
      logic [31:0] ed[6];
      ed = '{32'd2, 32'd2, 32'h0000_4000, 32'h0, 32'hFFFF_0000, 32'h0000_4000};
      load_plan_tensors();
      a_delay = 0; b_delay = 0; d_delay = 0;
      run_job(0, 2, 0, 6, 16, 22, 32, cy, to, es);
      checks++;
      if (to) begin errors++; $display("FAIL grad_plan timeout waiting for done"); end
      checks++;
      if (got_addr.size() != 6) begin
         errors++; $display("FAIL grad_plan write count got %0d want 6", got_addr.size());
      end else begin
         for (int k = 0; k < 6; k++) begin
            checks++;
            if (got_addr[k] !== 16'(32+k) || got_data[k] !== ed[k] || got_flush[k] !== (k == 5)) begin
               errors++;
               $display("FAIL grad_plan write %0d got a=%0d d=%h f=%0b want a=%0d d=%h f=%0b",
                        k, got_addr[k], got_data[k], got_flush[k], 32+k, ed[k], k == 5);
            end
         end
      end
      checks++;
      if (done_rise_cyc !== last_ack_cyc + 1) begin
         errors++; $display("FAIL grad_plan done_timing got cycle %0d want %0d", done_rise_cyc, last_ack_cyc + 1);
      end
      checks++;
      if (es !== 1'b0) begin errors++; $display("FAIL grad_plan err got %0b want 0", es); end
   endtask

   task automatic test_loss_plan;
      int cy; bit to, es;
      logic [31:0] ed[3];
      ed = '{32'd1, 32'd1, 32'h0004_8000};
      load_plan_tensors();
      run_job(1, 0, 0, 6, 16, 22, 32, cy, to, es);
      checks++;
      if (to) begin errors++; $display("FAIL loss_plan timeout waiting for done"); end
      checks++;
      if (got_addr.size() != 3) begin
         errors++; $display("FAIL loss_plan write count got %0d want 3", got_addr.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (got_addr[k] !== 16'(32+k) || got_data[k] !== ed[k] || got_flush[k] !== (k == 2)) begin
               errors++;
               $display("FAIL loss_plan write %0d got a=%0d d=%h f=%0b want a=%0d d=%h f=%0b",
                        k, got_addr[k], got_data[k], got_flush[k], 32+k, ed[k], k == 2);
            end
         end
      end
      checks++;
      if (cy != 17) begin errors++; $display("FAIL loss_plan cycles got %0d want 17", cy); end
   endtask

   task automatic test_saturation;
      int cy; bit to, es;
      set_hdr(0, 64, 1, 1); mem_a[66] = 32'h7FFF_FFFF;
      set_hdr(1, 80, 1, 1); mem_b[82] = 32'h8000_0000;
      for (int md = 0; md < 2; md++) begin
         run_job(md[0], 0, 64, 67, 80, 83, 96, cy, to, es);
         checks++;
         if (to || got_data.size() != 3) begin
            errors++; $display("FAIL saturation mode %0d got %0d writes (timeout %0b) want 3", md, got_data.size(), to);
         end else begin
            checks++;
            if (got_data[2] !== 32'h7FFF_FFFF) begin
               errors++; $display("FAIL saturation mode %0d value got %h want 7fffffff", md, got_data[2]);
            end
         end
      end
   endtask

   task automatic test_mismatch;
      int cy; bit to, es;
      load_plan_tensors();
      set_hdr(1, 112, 1, 4);
      for (int k = 0; k < 4; k++) mem_b[114+k] = $urandom;
      run_job(0, 1, 0, 6, 112, 118, 32, cy, to, es);
      checks++;
      if (to || es !== 1'b1) begin errors++; $display("FAIL mismatch err got %0b (timeout %0b) want 1", es, to); end
      checks++;
      if (wr_seen) begin errors++; $display("FAIL mismatch d_wr_en got asserted want never"); end
      checks++;
      if (err !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL mismatch after_go_low got err=%0b done=%0b want 0 0", err, done);
      end
      @(posedge clk); #1;
      checks++;
      if ({a_rd_en, b_rd_en, d_wr_en, done} !== 4'b0) begin
         errors++; $display("FAIL mismatch idle got %b want 0000", {a_rd_en, b_rd_en, d_wr_en, done});
      end
   endtask

   task automatic test_skew;
      int cy; bit to, es;
      set_hdr(0, 0, 2, 2); set_hdr(1, 16, 2, 2);
      for (int k = 0; k < 4; k++) begin mem_a[2+k] = $urandom; mem_b[18+k] = $urandom; end
      a_delay = 3; b_delay = 0; d_delay = 0;
      b_runs.delete(); b_thresh = 16'd18;
      model_job(0, 1, 0, 6, 16, 22, 40);
      run_job(0, 1, 0, 6, 16, 22, 40, cy, to, es);
      b_thresh = 16'hFFFF; a_delay = 0;
      checks++;
      if (to || got_addr.size() != exp_addr.size()) begin
         errors++; $display("FAIL skew write count got %0d want %0d", got_addr.size(), exp_addr.size());
      end else begin
         for (int k = 0; k < exp_addr.size(); k++) begin
            checks++;
            if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k] || got_flush[k] !== exp_flush[k]) begin
               errors++; $display("FAIL skew write %0d got a=%0d d=%h f=%0b want a=%0d d=%h f=%0b",
                                  k, got_addr[k], got_data[k], got_flush[k], exp_addr[k], exp_data[k], exp_flush[k]);
            end
         end
      end
      checks++;
      if (b_runs.size() != 4) begin errors++; $display("FAIL skew b_requests got %0d want 4", b_runs.size()); end
      foreach (b_runs[k]) begin
         checks++;
         if (b_runs[k] != 1) begin errors++; $display("FAIL skew b_rd_en_len[%0d] got %0d want 1", k, b_runs[k]); end
      end
   endtask

   task automatic test_empty;
      int cy; bit to, es;
      set_hdr(0, 128, 3, 0); set_hdr(1, 136, 3, 0);
      for (int md = 0; md < 2; md++) begin
         model_job(md[0], 0, 128, 130, 136, 138, 144);
         run_job(md[0], 0, 128, 130, 136, 138, 144, cy, to, es);
         checks++;
         if (to || got_addr.size() != (md == 0 ? 2 : 3)) begin
            errors++; $display("FAIL empty mode %0d write count got %0d want %0d", md, got_addr.size(), md == 0 ? 2 : 3);
         end else begin
            for (int k = 0; k < got_addr.size(); k++) begin
               checks++;
               if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k] || got_flush[k] !== exp_flush[k]) begin
                  errors++; $display("FAIL empty mode %0d write %0d got a=%0d d=%h f=%0b want a=%0d d=%h f=%0b", md, k,
                                     got_addr[k], got_data[k], got_flush[k], exp_addr[k], exp_data[k], exp_flush[k]);
               end
            end
         end
      end
   endtask

   task automatic test_reset_midjob;
      int cy; bit to, es, found;
      load_plan_tensors();
      d_delay = 3;
      mode = 0; grad_shift = 5'd2;
      a_begin = 16'd0; a_end = 16'd6; b_begin = 16'd16; b_end = 16'd22; d_begin = 16'd48;
      go = 1; found = 0;
      for (int k = 0; k < 300; k++) begin
         @(posedge clk); #1;
         if (d_wr_en && d_addr == 16'd50) begin found = 1; break; end
      end
      checks++;
      if (!found) begin errors++; $display("FAIL reset_midjob never reached data write"); end
      rst_l = 0;
      #1;
      checks++;
      if ({done, err, a_rd_en, b_rd_en, d_wr_en, d_flush} !== 6'b0 || {a_addr, b_addr, d_addr, d_wdata} !== 80'h0) begin
         errors++; $display("FAIL reset_midjob outputs got ctrl=%b a=%h b=%h d=%h w=%h want all 0",
                            {done, err, a_rd_en, b_rd_en, d_wr_en, d_flush}, a_addr, b_addr, d_addr, d_wdata);
      end
      go = 0;
      repeat (2) @(posedge clk);
      #1 rst_l = 1;
      d_delay = 0;
      @(posedge clk); #1;
      model_job(0, 2, 0, 6, 16, 22, 48);
      run_job(0, 2, 0, 6, 16, 22, 48, cy, to, es);
      checks++;
      if (to || got_addr.size() != exp_addr.size()) begin
         errors++; $display("FAIL reset_midjob restart write count got %0d want %0d", got_addr.size(), exp_addr.size());
      end else begin
         for (int k = 0; k < exp_addr.size(); k++) begin
            checks++;
            if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k] || got_flush[k] !== exp_flush[k]) begin
               errors++; $display("FAIL reset_midjob restart write %0d got a=%0d d=%h want a=%0d d=%h",
                                  k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
            end
         end
      end
   endtask

   task automatic test_random;
      int cy, rows, cols, n, sh; bit to, es, md;
      for (int it = 0; it < 10; it++) begin
         rows = $urandom_range(1, 3); cols = $urandom_range(1, 3); n = rows * cols;
         md = $urandom_range(0, 1); sh = (it % 2) ? $urandom_range(0, 31) : $urandom_range(0, 3);
         a_delay = $urandom_range(0, 2); b_delay = $urandom_range(0, 2); d_delay = $urandom_range(0, 2);
         set_hdr(0, 0, rows, cols); set_hdr(1, 64, rows, (it % 4 == 3) ? cols + 1 : cols);
         for (int k = 0; k < n; k++) begin
            if (it % 2) begin mem_a[2+k] = $urandom; mem_b[66+k] = $urandom; end
            else begin
               mem_a[2+k] = 32'($signed($urandom_range(0, 32'h7FFFF)) - 32'sh40000);
               mem_b[66+k] = 32'($signed($urandom_range(0, 32'h7FFFF)) - 32'sh40000);
            end
         end
         model_job(md, sh, 0, 2+n, 64, 66+n, 128);
         run_job(md, sh, 0, 2+n, 64, 66+n, 128, cy, to, es);
         checks++;
         if (to || es !== exp_err) begin
            errors++; $display("FAIL random[%0d] err got %0b (timeout %0b) want %0b", it, es, to, exp_err);
         end
         checks++;
         if (got_addr.size() != exp_addr.size()) begin
            errors++; $display("FAIL random[%0d] write count got %0d want %0d", it, got_addr.size(), exp_addr.size());
         end else begin
            for (int k = 0; k < exp_addr.size(); k++) begin
               checks++;
               if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k] || got_flush[k] !== exp_flush[k]) begin
                  errors++; $display("FAIL random[%0d] write %0d got a=%0d d=%h f=%0b want a=%0d d=%h f=%0b", it, k,
                                     got_addr[k], got_data[k], got_flush[k], exp_addr[k], exp_data[k], exp_flush[k]);
               end
            end
         end
      end
      a_delay = 0; b_delay = 0; d_delay = 0;
   endtask

   initial begin
      test_reset();
      test_grad_plan();
      test_loss_plan();
      test_saturation();
      test_mismatch();
      test_skew();
      test_empty();
      test_reset_midjob();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/loss_grad_unit.md
# loss_grad_unit

Parametrised fixed-point loss engine for the training datapath. It streams a prediction tensor A and a target tensor B from memory and computes one of two results. In gradient mode it writes the element-wise MSE gradient to tensor D. In loss mode it writes the scalar sum of squared errors. It is the successor to the single-mode MSE backward block. It adds:
- configurable width and fixed-point format;
- runtime mode select and gradient scaling;
- independent per-channel read handshakes;
- shape checking, saturation and an error flag.

## Interface
Parameters:
- WIDTH, 32: data word width, signed two's-complement fixed point.
- FRAC_BITS, 16: fractional bits of the fixed-point format.
- ADDR_W, 16: address width.

Ports:
- clk  in  1  clock.
- rst_l  in  1  reset, asynchronous, active-low.
- go  in  1  start request, level; sampled in IDLE.
- mode  in  1  0 = gradient, 1 = loss; captured when go is accepted.
- grad_shift  in  5  arithmetic right shift applied to each gradient; captured when go is accepted.
- a_begin, a_end  in  ADDR_W  A region, end exclusive; captured when go is accepted.
- b_begin, b_end  in  ADDR_W  B region, end exclusive; captured when go is accepted.
- d_begin  in  ADDR_W  D region base; captured when go is accepted.
- done  out  1  high in DONE.
- err  out  1  shape mismatch detected; valid while done is high.
- a_rd_en  out  1  read request on the A port.
- a_addr  out  ADDR_W  A read address.
- a_ack  in  1  A read acknowledge; a_rdata is valid in the same cycle.
- a_rdata  in  WIDTH  A read data.
- b_rd_en, b_addr, b_ack, b_rdata: same as the A port, for B.
- d_wr_en  out  1  write request.
- d_addr  out  ADDR_W  D write address.
- d_wdata  out  WIDTH  D write data.
- d_flush  out  1  write-through hint; high only with the final write of a job.
- d_ack  in  1  write acknowledge.

## Operation
- Tensor layout: word 0 = rows, word 1 = cols, data from word 2. Element count N = end - begin - 2.
- States: IDLE, HDR_RD, CHECK, HDR_WR0, HDR_WR1, RD, EXEC, WR, LOSS_WR, DONE.
- IDLE: go=1 captures all inputs and moves to HDR_RD.
- HDR_RD: reads words 0 and 1 of A, then words 0 and 1 of B, sequentially.
- CHECK: if A rows ≠ B rows, A cols ≠ B cols, or N_A ≠ N_B, set err and go to DONE. No D writes occur.
- HDR_WR0 / HDR_WR1: write the D header.
  - Gradient mode: copy of the A header.
  - Loss mode: 1, 1.
- RD: request A[i] and B[i] concurrently.
  - Each channel holds its rd_en until its own ack, latches rdata on that ack, then drops its request.
  - Leave RD in the cycle where both channels are satisfied. Ack in the same cycle as the request is legal.
- EXEC: diff = a - b, computed in WIDTH+1 bits.
  - Gradient: g = (2·diff) >>> grad_shift, saturated to signed WIDTH.
  - Loss: acc += (diff·diff) >>> FRAC_BITS. acc is 2·WIDTH+2 bits, unsigned, saturating.
- WR (gradient mode only): write g to d_begin+2+i. Then i++ and go to RD, or to DONE after the last element.
- Loss mode: after the last EXEC, go to LOSS_WR. Write min(acc, 2^(WIDTH-1)-1) to d_begin+2.
- d_flush is high with the last D write of the job:
  - the final WR;
  - LOSS_WR;
  - HDR_WR1 when N=0 in gradient mode.
- N=0 in loss mode: LOSS_WR writes 0.
- DONE: stay until go=0, then return to IDLE. err clears when leaving DONE.
- go toggling mid-job is ignored.

## Timing
- Reset: all of the following are 0, and the FSM is in IDLE:
  - done, err, a_rd_en, b_rd_en, d_wr_en, d_flush;
  - all addresses, d_wdata, acc and i.
- Reset mid-job aborts immediately. No partial request remains asserted after reset.
- Request outputs are decoded from registered state and flags; they are glitch-free.
- Address and data are stable while the matching enable is high.
- A request drops in the cycle after its ack is sampled.
- With zero-wait acks:
  - header phase: 4 read cycles, 1 CHECK, 2 write cycles;
  - gradient: 3 cycles per element (RD, EXEC, WR);
  - loss: 2 cycles per element, plus 1 LOSS_WR.
  - done rises on the cycle after the final write's ack.
- Wait states: every handshake state stretches by the number of ack-delay cycles. Nothing else changes.
- Skew between a_ack and b_ack in RD: the earlier channel's data is held. No re-request is issued.

## Test plan
- Gradient, 2×2 tensors, FRAC_BITS=16, grad_shift=2. A = {1.0, 2.0, -1.0, 0.5}, B = {0.5, 2.0, 1.0, 0.0}.
  - Required D: header {2,2}, data {0.25, 0, -1.0, 0.25}.
  - d_flush high only on the 4th data write. done rises one cycle after its ack.
- Loss, same A and B.
  - Required D: {1, 1, 4.5}, i.e. 0x00048000.
  - Total cycles with zero-wait acks: 7 + 8 + 1 + 1.
- Saturation: A = {0x7FFFFFFF}, B = {0x80000000}, grad_shift=0.
  - Gradient = 0x7FFFFFFF. Loss = 0x7FFFFFFF.
- Shape mismatch: A is 2×2, B is 1×4.
  - err=1 with done; d_wr_en never asserts.
  - After go is dropped, err=0 and the FSM is in IDLE.
- Ack skew and empty tensor:
  - a_ack 3 cycles late, b_ack immediate: b_rd_en drops after 1 cycle, and the data pair is correct.
  - N=0 in gradient mode: only 2 header writes, with d_flush on the second.
- Reset mid-job: assert rst_l=0 during WR with d_wr_en high.
  - All outputs are 0 in the same cycle.
  - A restart with go produces a correct, complete result.
